// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from a valid/ready command channel to APB SETUP/ACCESS
// transfers, with a wait-state watchdog that aborts hung transfers with an error response.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    // Command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    // Response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // APB master side
    output logic                    PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    // Debug view of the FSM
    output logic [1:0]              dbg_state
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam int CNT_WIDTH  = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = WDOG_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1)
                                                        : CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   wait_cnt;
    logic                   accept;
    logic                   access_done;
    logic                   access_timeout;

    // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
    // valid must stay asserted with stable payload until that edge, and ready never depends
    // combinationally on valid.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        access_done    = 1'b0;
        access_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: state_next = S_ACCESS;
            S_ACCESS: begin
                // PREADY wins over the watchdog when both fire in the same cycle.
                if (PREADY) begin
                    access_done = 1'b1;
                    state_next  = S_RESP;
                end else if (WDOG_EN && (wait_cnt == CNT_LAST)) begin
                    access_timeout = 1'b1;
                    state_next     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign PSELx     = (state == S_SETUP) || (state == S_ACCESS);
    assign PENABLE   = (state == S_ACCESS);
    assign rsp_valid = (state == S_RESP);
    assign dbg_state = state;

    // cmd_ready is registered so it stays low while reset is held and rises one edge later.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cmd_ready <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            cmd_ready <= (state_next == S_IDLE);

            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_write ? cmd_wdata : '0;
                PSTRB  <= cmd_write ? cmd_strb : STRB_WIDTH'(0);
            end

            if (access_done) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= 1'b0;
            end else if (access_timeout) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end

            if ((state == S_RESP) && rsp_ready) begin
                wait_cnt <= '0;
            end else if ((state == S_ACCESS) && !PREADY && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus randomized transfers, checked
// against a transaction-level model of the expected response and ACCESS length.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW:0] exp_q[$];   // {err, rdata} per issued command

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .dbg_state (dbg_state)
    );

    // Clock
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: outcome of one transfer given how long the slave stalls.
    function automatic bit model_timeout(int waits);
        return (TO != 0) && (waits >= TO);
    endfunction

    function automatic logic [DW:0] model_rsp(bit wr, int waits, logic [DW-1:0] sdata);
        if (model_timeout(waits)) return {1'b1, {DW{1'b0}}};
        if (wr) return '0;
        return {1'b0, sdata};
    endfunction

    function automatic int model_access_cycles(int waits);
        return model_timeout(waits) ? TO : waits + 1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, "_apb_ctrl"}, {PSELx, PENABLE, PWRITE}, 3'b000);
        check({tag, "_paddr"}, PADDR, '0);
        check({tag, "_pwdata_pstrb"}, {PWDATA, PSTRB}, '0);
        check({tag, "_rsp_ctrl"}, {rsp_valid, rsp_err}, 2'b00);
        check({tag, "_rsp_rdata"}, rsp_rdata, '0);
    endtask

    // Drives one command, plays the slave with `waits` PREADY-low cycles, holds off the
    // response for rsp_hold cycles (presenting a stray command meanwhile). A nonzero
    // reset_at pulses reset in that ACCESS cycle and abandons the transfer.
    task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] strb, input int waits, input int rsp_hold,
                            input logic [DW-1:0] sdata, input int reset_at);
        int            acc;
        int            guard;
        logic [DW-1:0] exp_pwdata;
        logic [SW-1:0] exp_pstrb;
        logic [DW:0]   exp_rsp;
        exp_pwdata = wr ? wdata : '0;
        exp_pstrb  = wr ? strb : '0;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        cmd_strb  = SW'($urandom);
        check("setup_phase", {PSELx, PENABLE, cmd_ready, rsp_valid}, 4'b1000);
        check("setup_fields", {PADDR, PWRITE, PWDATA, PSTRB}, {addr, wr, exp_pwdata, exp_pstrb});
        exp_q.push_back(model_rsp(wr, waits, sdata));
        @(negedge PCLK);
        acc = 0;
        while (PSELx && PENABLE && acc < 100) begin
            acc++;
            check("access_fields", {PADDR, PWRITE, PWDATA, PSTRB}, {addr, wr, exp_pwdata, exp_pstrb});
            check("access_busy", {cmd_ready, rsp_valid}, 2'b00);
            if (acc == reset_at) begin
                PRESETn = 1'b0;
                PREADY  = 1'b0;
                @(negedge PCLK);
                check_reset_vals("mid_access_reset");
                exp_q.delete();
                PRESETn = 1'b1;
                @(negedge PCLK);
                check("post_reset_idle", {PSELx, PENABLE, cmd_ready, rsp_valid}, 4'b0010);
                return;
            end
            PREADY = (acc > waits);
            PRDATA = PREADY ? sdata : DW'($urandom);
            @(negedge PCLK);
        end
        PREADY = 1'b0;
        PRDATA = DW'($urandom);
        check("access_cycles", acc, model_access_cycles(waits));
        check("resp_phase", {PSELx, PENABLE, cmd_ready, rsp_valid}, 4'b0001);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", exp_q.size(), 1);
            exp_rsp = '0;
        end else begin
            exp_rsp = exp_q.pop_front();
            check("resp_data", {rsp_err, rsp_rdata}, exp_rsp);
        end
        for (int i = 0; i < rsp_hold; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'($urandom);
            cmd_addr  = AW'($urandom);
            @(negedge PCLK);
            check("resp_hold", {PSELx, PENABLE, cmd_ready, rsp_valid}, 4'b0001);
            check("resp_stable", {rsp_err, rsp_rdata}, exp_rsp);
        end
        check("resp_fields_held", {PADDR, PWRITE, PWDATA, PSTRB}, {addr, wr, exp_pwdata, exp_pstrb});
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("back_to_idle", {PSELx, PENABLE, cmd_ready, rsp_valid}, 4'b0010);
    endtask

    initial begin
        bit            r_wr;
        int            r_waits;
        logic [AW-1:0] r_addr;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        repeat (3) @(negedge PCLK);
        check_reset_vals("reset");
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("reset_release_ready", cmd_ready, 1'b1);

        // Zero-wait write
        run_xfer(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 0);
        // Read with 3 wait states
        run_xfer(1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 3, 0, 32'h1234_5678, 0);
        // Watchdog: slave never responds
        run_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1000, 0, 32'hCAFE_F00D, 0);
        // PREADY arrives in the last cycle before the watchdog would fire
        run_xfer(1'b0, 32'h0000_0014, 32'h0, 4'h0, TO - 1, 0, 32'h0BAD_CAFE, 0);
        // Response backpressure with a stray command during RESP
        run_xfer(1'b1, 32'h0000_0020, 32'h5A5A_A5A5, 4'hC, 1, 5, 32'h0, 0);
        run_xfer(1'b0, 32'h0000_0024, 32'h0, 4'h0, 0, 0, 32'h7777_1111, 0);
        // Reset during a waited read, then a normal write
        run_xfer(1'b0, 32'h0000_0030, 32'h0, 4'h0, 10, 0, 32'h9999_9999, 3);
        run_xfer(1'b1, 32'h0000_0034, 32'h1357_9BDF, 4'hF, 0, 0, 32'h0, 0);
        // Partial strobe write then read back
        run_xfer(1'b1, 32'h0000_0004, 32'hAAAA_5555, 4'h3, 0, 0, 32'h0, 0);
        run_xfer(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1, 0, DW'($urandom), 0);

        for (int t = 0; t < 40; t++) begin
            r_wr    = 1'($urandom_range(0, 1));
            r_addr  = AW'($urandom) & ~AW'(3);
            r_waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 4)
                                                  : $urandom_range(0, 6);
            run_xfer(r_wr, r_addr, DW'($urandom), SW'($urandom), r_waits,
                     $urandom_range(0, 3), DW'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
